loba_div_seq: RTL

- Sequential approximate signed divider; the inverse operation to the LOBA leading-one-segment multipliers.
- Each operand is reduced to a K-bit leading-one segment and its position. A K+P cycle restoring divider divides the segments, and the result is rescaled by the difference of the leading-one positions.
- Sits alongside the LOBA multipliers in the approximate-arithmetic library, with valid/ready handshakes on both sides.

---
 rtl/loba_div_seq_if.sv | 29 ++
 rtl/loba_div_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/loba_div_seq_if.sv
// Handshake bundle for loba_div_seq.
// Request side:  in_valid/in_ready carry the signed operands a (NA bits) and b (NB bits).
// Response side: out_valid/out_ready carry the quotient q (NA bits) and the
//                div_by_zero / ovf flags.
// master: the producer/consumer around the divider; slave: the divider itself.
interface loba_div_seq_if #(
  parameter int unsigned NA = 16,
  parameter int unsigned NB = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [NA-1:0] a;
  logic [NB-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [NA-1:0] q;
  logic          div_by_zero;
  logic          ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero, ovf
  );
endinterface

// File: rtl/loba_div_seq.sv
// Sequential approximate signed divider using leading-one segments.
// Each operand magnitude is cut down to a K-bit segment at its leading one. The
// segments are divided by a K+P step restoring divider, and the quotient is
// rescaled by the difference of the leading-one positions, then saturated and
// signed.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of loba_div_seq_if (operand and result handshakes)
module loba_div_seq #(
  parameter int unsigned K  = 4,
  parameter int unsigned NA = 16,
  parameter int unsigned NB = 8,
  parameter int unsigned P  = 4
) (
  input logic           clk,
  input logic           rst_n,
  loba_div_seq_if.slave bus
);

  localparam int unsigned QW   = K + P;
  localparam int unsigned CntW = (QW > 1) ? $clog2(QW) : 1;
  localparam int unsigned IdxW = $clog2(NA);
  localparam int unsigned W    = NA + K + P;

  typedef enum logic [2:0] {StIdle, StNorm, StDiv, StScale, StDone} state_e;

  state_e          state_q, state_d;
  logic [NA-1:0]   a_q, a_d;
  logic [NB-1:0]   b_q, b_d;
  logic [K-1:0]    bh_q, bh_d;
  logic [QW-1:0]   dvd_q, dvd_d;
  logic [K:0]      rem_q, rem_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] ka_q, ka_d, kb_q, kb_d;
  logic            sign_q, sign_d;
  logic [NA-1:0]   q_q, q_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;

  logic [NA-1:0]   a_mag;
  logic [NB-1:0]   b_mag;
  int unsigned     ka_i, kb_i;
  logic [K:0]      rem_sh;
  int              s;
  logic [W-1:0]    mag_w, lim_w;

  // Leading-one index, clamped from below at K-1 (also covers a zero input).
  function automatic int unsigned lead_idx(input logic [NA-1:0] v);
    int unsigned idx;
    idx = K - 1;
    for (int i = int'(K); i < int'(NA); i++) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bh_d    = bh_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    sign_d  = sign_q;
    q_d     = q_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    a_mag  = a_q[NA-1] ? (~a_q + 1'b1) : a_q;
    b_mag  = b_q[NB-1] ? (~b_q + 1'b1) : b_q;
    ka_i   = lead_idx(a_mag);
    kb_i   = lead_idx(NA'(b_mag));
    rem_sh = {rem_q[K-1:0], dvd_q[QW-1]};
    s      = int'(ka_q) - int'(kb_q) - int'(P);
    mag_w  = W'(quo_q);
    lim_w  = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = StNorm;
        end
      end
      StNorm: begin
        sign_d = a_q[NA-1] ^ b_q[NB-1];
        dz_d   = (b_mag == '0);
        ovf_d  = 1'b0;
        q_d    = '0;
        ka_d   = IdxW'(ka_i);
        kb_d   = IdxW'(kb_i);
        bh_d   = K'(NA'(b_mag) >> (kb_i - (K - 1)));
        dvd_d  = {K'(a_mag >> (ka_i - (K - 1))), {P{1'b0}}};
        rem_d  = '0;
        quo_d  = '0;
        cnt_d  = '0;
        // Divide-by-zero also passes through SCALE so both paths share the
        // final output register stage.
        state_d = (b_mag == '0) ? StScale : StDiv;
      end
      StDiv: begin
        if (rem_sh >= {1'b0, bh_q}) begin
          rem_d = rem_sh - {1'b0, bh_q};
          quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[QW-2:0], 1'b0};
        end
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(QW - 1)) state_d = StScale;
      end
      StScale: begin
        if (dz_q) begin
          q_d   = '0;
          ovf_d = 1'b0;
        end else begin
          if (s >= 0) mag_w = mag_w << s;
          else        mag_w = mag_w >> (-s);
          // Negative results may reach one further than positive ones.
          lim_w = sign_q ? (W'(1) << (NA - 1)) : ((W'(1) << (NA - 1)) - 1'b1);
          if (mag_w > lim_w) begin
            mag_w = lim_w;
            ovf_d = 1'b1;
          end else begin
            ovf_d = 1'b0;
          end
          q_d = sign_q ? (~mag_w[NA-1:0] + 1'b1) : mag_w[NA-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      bh_q    <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      ka_q    <= '0;
      kb_q    <= '0;
      sign_q  <= 1'b0;
      q_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bh_q    <= bh_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      sign_q  <= sign_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.q           = q_q;
  assign bus.div_by_zero = dz_q;
  assign bus.ovf         = ovf_q;

endmodule
